// File: rtl/imm_issue_ctrl.sv
// rtl/imm_issue_ctrl.sv - ID-stage 2-entry issue queue with immediate-select decode
// Drives the shared immediate generator from the queue head and hands results to ID/EX.
module imm_issue_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic [2:0]       ssf_sel,
  output logic [24:0]      ssf_inst,
  input  logic [31:0]      ssf_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_imm,
  output logic             out_imm_vld,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_inst [2];
  logic [PC_W-1:0]  r_pc   [2];
  logic             r_rd;
  logic             r_wr;
  logic [CNT_W-1:0] r_issued;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_inst;
  logic [PC_W-1:0]  w_head_pc;
  logic [2:0]       w_sel;
  logic             w_imm_vld;
  logic             w_illegal;

  assign in_ready    = (r_state != S_FULL);
  assign out_valid   = (r_state != S_EMPTY);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_head_inst = r_inst[r_rd];
  assign w_head_pc   = r_pc[r_rd];
  assign issued_cnt  = r_issued;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_FULL;
        else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
    // Redirect wins over everything, including a push in the same cycle.
    if (flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_EMPTY;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_issued <= '0;
      r_inst[0] <= '0;
      r_inst[1] <= '0;
      r_pc[0]   <= '0;
      r_pc[1]   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_issued <= r_issued + CNT_W'(1);
      if (flush) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
      end else begin
        if (w_push) begin
          r_inst[r_wr] <= in_inst;
          r_pc[r_wr]   <= in_pc;
          r_wr         <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
      end
    end
  end

  always_comb begin
    w_sel     = 3'd0;
    w_imm_vld = 1'b0;
    w_illegal = 1'b0;
    if (w_head_inst[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_head_inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin w_sel = 3'd0; w_imm_vld = 1'b1; end
        7'b0100011:                         begin w_sel = 3'd1; w_imm_vld = 1'b1; end
        7'b0110111, 7'b0010111:             begin w_sel = 3'd2; w_imm_vld = 1'b1; end
        7'b1100011:                         begin w_sel = 3'd3; w_imm_vld = 1'b1; end
        7'b1101111:                         begin w_sel = 3'd4; w_imm_vld = 1'b1; end
        7'b0110011, 7'b0001111, 7'b1110011: w_sel = 3'd0;
        default:                            w_illegal = 1'b1;
      endcase
    end
  end

  // Everything downstream reads zero when no head entry is presented.
  assign ssf_sel     = out_valid ? w_sel : 3'd0;
  assign ssf_inst    = out_valid ? w_head_inst[31:7] : 25'd0;
  assign out_inst    = out_valid ? w_head_inst : 32'd0;
  assign out_pc      = out_valid ? w_head_pc : '0;
  assign out_imm_vld = out_valid & w_imm_vld;
  assign out_illegal = out_valid & w_illegal;
  assign out_imm     = (out_valid && w_imm_vld) ? ssf_imm : 32'd0;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// tb/tb_imm_issue_ctrl.sv - self-checking bench for imm_issue_ctrl
// Queue-level reference model checked every cycle, plus directed literal expectations.
module tb_imm_issue_ctrl;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic [2:0]  ssf_sel;
  logic [24:0] ssf_inst;
  logic [31:0] ssf_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic        out_imm_vld;
  logic        out_illegal;
  logic [7:0]  issued_cnt;

  int errors = 0;
  int checks = 0;

  imm_issue_ctrl #(.PC_W(32), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .ssf_sel(ssf_sel), .ssf_inst(ssf_inst), .ssf_imm(ssf_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_imm_vld(out_imm_vld), .out_illegal(out_illegal),
    .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V immediate formats computed from the whole instruction word.
  function automatic logic [31:0] ref_imm(input logic [2:0] sel, input logic [31:0] i);
    case (sel)
      3'd0:    ref_imm = {{20{i[31]}}, i[31:20]};
      3'd1:    ref_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    ref_imm = {i[31:12], 12'd0};
      3'd3:    ref_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    ref_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: ref_imm = 32'd0;
    endcase
  endfunction

  // Stand-in for the shared immediate generator.
  always_comb ssf_imm = ref_imm(ssf_sel, {ssf_inst, 7'd0});

  // Returns {illegal, imm_vld, sel} straight from the opcode table.
  function automatic logic [4:0] ref_decode(input logic [31:0] i);
    if (i[1:0] != 2'b11) return {1'b1, 1'b0, 3'd0};
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return {1'b0, 1'b1, 3'd0};
      7'h23:               return {1'b0, 1'b1, 3'd1};
      7'h37, 7'h17:        return {1'b0, 1'b1, 3'd2};
      7'h63:               return {1'b0, 1'b1, 3'd3};
      7'h6f:               return {1'b0, 1'b1, 3'd4};
      7'h33, 7'h0f, 7'h73: return {1'b0, 1'b0, 3'd0};
      default:             return {1'b1, 1'b0, 3'd0};
    endcase
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] m_cnt;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      m_cnt = 8'd0;
    end else begin
      automatic bit   do_push = in_valid && (mq.size() < 2);
      automatic bit   do_pop  = out_ready && (mq.size() > 0);
      automatic ent_t e;
      e.inst = in_inst;
      e.pc   = in_pc;
      if (do_pop) m_cnt = m_cnt + 8'd1;
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      automatic logic [4:0]  d = 5'd0;
      automatic logic [31:0] hi = 32'd0;
      automatic logic [31:0] hp = 32'd0;
      automatic logic        v = (mq.size() > 0);
      if (v) begin
        hi = mq[0].inst;
        hp = mq[0].pc;
        d  = ref_decode(hi);
      end
      chk("m_in_ready",  in_ready,    mq.size() < 2);
      chk("m_out_valid", out_valid,   v);
      chk("m_out_inst",  out_inst,    hi);
      chk("m_out_pc",    out_pc,      hp);
      chk("m_ssf_sel",   ssf_sel,     d[2:0]);
      chk("m_ssf_inst",  ssf_inst,    hi[31:7]);
      chk("m_imm_vld",   out_imm_vld, d[3]);
      chk("m_illegal",   out_illegal, d[4]);
      chk("m_out_imm",   out_imm,     d[3] ? ref_imm(d[2:0], hi) : 32'd0);
      chk("m_issued",    issued_cnt,  m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready,    1'b1);
    chk({tag, "_out_valid"}, out_valid,   1'b0);
    chk({tag, "_out_inst"},  out_inst,    32'd0);
    chk({tag, "_out_pc"},    out_pc,      32'd0);
    chk({tag, "_out_imm"},   out_imm,     32'd0);
    chk({tag, "_imm_vld"},   out_imm_vld, 1'b0);
    chk({tag, "_illegal"},   out_illegal, 1'b0);
    chk({tag, "_ssf_sel"},   ssf_sel,     3'd0);
    chk({tag, "_ssf_inst"},  ssf_inst,    25'd0);
    chk({tag, "_issued"},    issued_cnt,  8'd0);
  endtask

  logic [31:0] seq_inst [4];
  logic [2:0]  seq_sel  [4];
  logic [31:0] seq_imm  [4];

  initial begin
    seq_inst = '{32'hdeadb137, 32'h00208a63, 32'hfb1ff0ef, 32'h00102023};
    seq_sel  = '{3'd2, 3'd3, 3'd4, 3'd1};
    seq_imm  = '{32'hdeadb000, 32'h00000014, 32'hffffffb0, 32'h00000000};

    nrst = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    tick();
    nrst = 1'b1;

    // 1) single addi
    in_valid = 1'b1; in_inst = 32'h06300093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid",   out_valid,   1'b1);
    chk("t1_sel",     ssf_sel,     3'd0);
    chk("t1_imm",     out_imm,     32'h00000063);
    chk("t1_imm_vld", out_imm_vld, 1'b1);
    chk("t1_pc",      out_pc,      32'h100);
    tick();
    chk("t1_issued",  issued_cnt,  8'd1);
    chk("t1_empty",   out_valid,   1'b0);

    // 2) back-to-back stream
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_inst = seq_inst[k]; in_pc = 32'h200 + 32'(k * 4);
      tick();
      chk("t2_sel", ssf_sel, seq_sel[k]);
      chk("t2_imm", out_imm, seq_imm[k]);
      chk("t2_pc",  out_pc,  32'h200 + 32'(k * 4));
    end
    in_valid = 1'b0;
    tick();
    chk("t2_issued", issued_cnt, 8'd5);

    // 3) backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_inst = 32'h00000093 | (32'(k + 1) << 20); in_pc = 32'h300 + 32'(k);
      tick();
      chk("t3_ready", in_ready, k == 0);
      chk("t3_head",  out_inst, 32'h00100093);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_ready_after_pop", in_ready, 1'b1);
    chk("t3_head_b",          out_inst, 32'h00200093);
    tick();
    in_valid = 1'b0;
    chk("t3_head_c",          out_inst, 32'h00300093);
    chk("t3_imm_c",           out_imm,  32'd3);
    tick();
    chk("t3_drained",         out_valid, 1'b0);

    // 4) no-immediate and illegal opcodes
    in_valid = 1'b1; in_inst = 32'h00840333;
    tick();
    in_inst = 32'h0000007f;
    chk("t4_add_vld",     out_imm_vld, 1'b0);
    chk("t4_add_imm",     out_imm,     32'd0);
    chk("t4_add_illegal", out_illegal, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t4_ill",         out_illegal, 1'b1);
    chk("t4_ill_vld",     out_imm_vld, 1'b0);
    tick();

    // 5) flush on a full queue with a pending push
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00500093;
    tick();
    in_inst = 32'h00600093;
    tick();
    chk("t5_full", in_ready, 1'b0);
    in_inst = 32'h00700093; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_ready", in_ready,  1'b1);
    tick();
    chk("t5_still_empty", out_valid, 1'b0);

    // 6) async reset mid-stream, then counter wrap
    in_valid = 1'b1; in_inst = 32'h00800093;
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk_all_zero("areset");
    in_valid = 1'b0;
    tick();
    nrst = 1'b1;
    in_valid = 1'b1; in_inst = 32'h06300093; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 255; k++) tick();
    chk("t6_cnt255", issued_cnt, 8'd255);
    in_valid = 1'b0;
    tick();
    chk("t6_cnt_wrap", issued_cnt, 8'd0);
    chk("t6_empty",    out_valid,  1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
